// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants and state encoding for the 3x3 line-buffer window controller.
package line_buffer_ctrl_pkg;

  localparam int IMG_W    = 128;
  localparam int LB_COUNT = 4;
  localparam int ROW_W    = 24;
  localparam int WIN_W    = 3 * ROW_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } lb_state_e;

  // Buffers sel, sel+1 and sel+2 (mod 4) are the three rows being read.
  function automatic logic [LB_COUNT-1:0] row_mask(input logic [1:0] sel);
    logic [LB_COUNT-1:0] m;
    m = '1;
    m[sel + 2'd3] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_window_mux.sv
// Rotating 4-to-3 row selector: picks the three line buffers forming the window, top row first.
module window_mux
  import line_buffer_ctrl_pkg::*;
(
  input  logic [1:0]                sel,
  input  logic [LB_COUNT*ROW_W-1:0] rd_data,
  output logic [WIN_W-1:0]          window,
  output logic [LB_COUNT-1:0]       rows
);

  logic [ROW_W-1:0] bufs [LB_COUNT];
  logic [1:0]       sel_mid;
  logic [1:0]       sel_bot;

  always_comb begin
    for (int n = 0; n < LB_COUNT; n++) begin
      bufs[n] = rd_data[ROW_W*n +: ROW_W];
    end
  end

  assign sel_mid = sel + 2'd1;
  assign sel_bot = sel + 2'd2;
  assign window  = {bufs[sel], bufs[sel_mid], bufs[sel_bot]};
  assign rows    = row_mask(sel);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Write/read pointer and fill bookkeeping for four external line buffers feeding a 3x3 window.
//   state | meaning
//   IDLE  | accumulating pixels until three full lines are stored
//   READ  | streaming one line of windows, one read per cycle
module line_buffer_ctrl #(
  parameter int IMG_W = line_buffer_ctrl_pkg::IMG_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  lb_wr_data,
  output logic [3:0]  lb_wr_valid,
  output logic [3:0]  lb_rd_ready,
  input  logic [95:0] lb_rd_data,
  output logic [71:0] out_window,
  output logic        out_valid,
  output logic        line_done
);

  import line_buffer_ctrl_pkg::*;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int FILL_W = $clog2(LB_COUNT * IMG_W + 1);

  localparam logic [FILL_W-1:0] FILL_MAX       = FILL_W'(LB_COUNT * IMG_W);
  localparam logic [FILL_W-1:0] FILL_START     = FILL_W'(3 * IMG_W);
  localparam logic [FILL_W-1:0] FILL_ONE       = FILL_W'(1);
  localparam logic [COL_W-1:0]  COL_ONE        = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST       = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_LAST_VALID = COL_W'(IMG_W - 3);

  lb_state_e          state;
  lb_state_e          state_next;
  logic [COL_W-1:0]   wr_col;
  logic [1:0]         wr_sel;
  logic [COL_W-1:0]   rd_col;
  logic [1:0]         rd_sel;
  logic [FILL_W-1:0]  fill_cnt;
  logic               accept;
  logic               read;
  logic [3:0]         rows;

  assign in_ready    = (fill_cnt < FILL_MAX);
  assign accept      = in_valid && in_ready;
  assign lb_wr_data  = in_data;
  assign lb_wr_valid = accept ? (4'b0001 << wr_sel) : 4'b0000;

  window_mux u_window_mux (
    .sel     (rd_sel),
    .rd_data (lb_rd_data),
    .window  (out_window),
    .rows    (rows)
  );

  always_comb begin
    state_next  = state;
    read        = 1'b0;
    lb_rd_ready = 4'b0000;
    out_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fill_cnt >= FILL_START) state_next = ST_READ;
      end
      ST_READ: begin
        read        = 1'b1;
        lb_rd_ready = rows;
        // The final two columns only realign the buffer read pointers.
        out_valid   = (rd_col <= COL_LAST_VALID);
        if (rd_col == COL_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_col    <= '0;
      wr_sel    <= 2'd0;
      rd_col    <= '0;
      rd_sel    <= 2'd0;
      fill_cnt  <= '0;
      line_done <= 1'b0;
    end else begin
      state     <= state_next;
      line_done <= read && (rd_col == COL_LAST);

      if (accept) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_col <= wr_col + COL_ONE;
        end
      end

      if (read) begin
        if (rd_col == COL_LAST) begin
          rd_col <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_col <= rd_col + COL_ONE;
        end
      end

      case ({accept, read})
        2'b10:   fill_cnt <= fill_cnt + FILL_ONE;
        2'b01:   fill_cnt <= fill_cnt - FILL_ONE;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl; line buffers are modelled as static per-buffer line tags.
module tb_line_buffer_ctrl;

  localparam int W = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  lb_wr_data;
  logic [3:0]  lb_wr_valid;
  logic [3:0]  lb_rd_ready;
  logic [95:0] lb_rd_data;
  logic [71:0] out_window;
  logic        out_valid;
  logic        line_done;

  int errors = 0;
  int checks = 0;
  int rot_k  = 0;
  int pushed = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.IMG_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lb_wr_data  (lb_wr_data),
    .lb_wr_valid (lb_wr_valid),
    .lb_rd_ready (lb_rd_ready),
    .lb_rd_data  (lb_rd_data),
    .out_window  (out_window),
    .out_valid   (out_valid),
    .line_done   (line_done)
  );

  // Buffer n holds the line L in rot_k..rot_k+3 with L mod 4 == n; every pixel of it carries tag L.
  always_comb begin
    lb_rd_data = '0;
    for (int n = 0; n < 4; n++) begin
      lb_rd_data[24*n +: 24] = {3{8'(rot_k + ((n - rot_k) & 3))}};
    end
  end

  function automatic logic [71:0] exp_win(input int k);
    return {{3{8'(k)}}, {3{8'(k + 1)}}, {3{8'(k + 2)}}};
  endfunction

  function automatic logic [3:0] exp_mask(input int k);
    logic [3:0] m;
    m = 4'hF;
    m[(k + 3) % 4] = 1'b0;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rot_k = 0;
    pushed = 0;
  endtask

  task automatic push_pixels(input int n, input int line0);
    int cyc;
    logic acc;
    cyc = 0;
    pushed = 0;
    while (pushed < n && cyc < 20 * n) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(line0 + pushed / W);
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) pushed++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (lb_rd_ready !== 4'b0000) begin errors++; $display("FAIL reset_rd_ready: got %b want 0000", lb_rd_ready); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done: got %0b want 0", line_done); end
    checks++; if (lb_wr_valid !== 4'b0000) begin errors++; $display("FAIL reset_wr_valid: got %b want 0000", lb_wr_valid); end
    reset = 1'b0;
  endtask

  task automatic test_fill_threshold();
    int sent, cyc, bad_d, early;
    int bad_g [3];
    logic acc;
    logic [3:0] exp_wv;
    do_reset();
    sent = 0; cyc = 0; bad_d = 0; early = 0;
    for (int g = 0; g < 3; g++) bad_g[g] = 0;
    while (sent < 3 * W && cyc < 1000) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(sent * 7);
      #1;
      acc = in_ready;
      exp_wv = 4'(1 << ((sent / W) % 4));
      if (acc && lb_wr_valid !== exp_wv) bad_g[sent / W]++;
      if (acc && lb_wr_data !== 8'(sent * 7)) bad_d++;
      if (lb_rd_ready !== 4'b0000) early++;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (sent !== 3 * W) begin errors++; $display("FAIL fill_accepted: got %0d want %0d", sent, 3 * W); end
    for (int g = 0; g < 3; g++) begin
      checks++; if (bad_g[g] !== 0) begin errors++; $display("FAIL fill_wr_valid_group%0d: got %0d bad cycles want 0", g, bad_g[g]); end
    end
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL fill_wr_data: got %0d bad cycles want 0", bad_d); end
    checks++; if (early !== 0) begin errors++; $display("FAIL fill_early_read: got %0d read cycles want 0", early); end
    checks++; if (lb_rd_ready !== 4'b0000) begin errors++; $display("FAIL fill_idle_after_384: got %b want 0000", lb_rd_ready); end
    @(negedge clk);
    #1;
    checks++; if (lb_rd_ready !== 4'b0111) begin errors++; $display("FAIL fill_read_entry: got %b want 0111", lb_rd_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_first_valid: got %0b want 1", out_valid); end
  endtask

  task automatic test_line_output();
    int nread, nvalid, badw, badm, order, cyc;
    bit done;
    do_reset();
    push_pixels(3 * W, 0);
    nread = 0; nvalid = 0; badw = 0; badm = 0; order = 0; cyc = 0; done = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      #1;
      cyc++;
      if (lb_rd_ready != 4'b0000) begin
        nread++;
        if (lb_rd_ready !== 4'b0111) badm++;
        if (out_valid) begin
          nvalid++;
          if (out_window !== exp_win(0)) badw++;
          if (nread > W - 2) order++;
        end else if (nread <= W - 2) begin
          order++;
        end
      end else if (out_valid) begin
        order++;
      end
      if (line_done) done = 1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL line_done_seen: got %0b want 1", done); end
    checks++; if (nvalid !== W - 2) begin errors++; $display("FAIL line_valid_count: got %0d want %0d", nvalid, W - 2); end
    checks++; if (nread !== W) begin errors++; $display("FAIL line_read_count: got %0d want %0d", nread, W); end
    checks++; if (order !== 0) begin errors++; $display("FAIL line_valid_order: got %0d misplaced want 0", order); end
    checks++; if (badw !== 0) begin errors++; $display("FAIL line_window: got %0d bad windows want 0", badw); end
    checks++; if (badm !== 0) begin errors++; $display("FAIL line_rd_mask: got %0d bad masks want 0", badm); end
    checks++; if (dut.rd_sel !== 2'd1) begin errors++; $display("FAIL line_rd_sel: got %0d want 1", dut.rd_sel); end
    checks++; if (dut.fill_cnt !== 10'd256) begin errors++; $display("FAIL line_fill_cnt: got %0d want 256", dut.fill_cnt); end
    @(negedge clk);
    #1;
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL line_done_pulse_width: got %0b want 0", line_done); end
    checks++; if (lb_rd_ready !== 4'b0000) begin errors++; $display("FAIL line_stays_idle: got %b want 0000", lb_rd_ready); end
  endtask

  task automatic test_rotation();
    int k, cyc, nvalid, badw, badm, rule, wr_bad;
    logic [3:0] seen;
    do_reset();
    k = 0; cyc = 0; nvalid = 0; badw = 0; badm = 0; rule = 0; wr_bad = 0; seen = 4'b0000;
    fork
      push_pixels(10 * W, 0);
      begin
        while (k < 8 && cyc < 8000) begin
          @(negedge clk);
          #2;
          cyc++;
          if (in_valid && in_ready) begin
            if (lb_wr_valid !== 4'(1 << ((pushed / W) % 4))) wr_bad++;
            seen = seen | lb_wr_valid;
          end
          if (!in_ready && lb_wr_valid != 4'b0000) rule++;
          if (in_ready !== (dut.fill_cnt < 10'd512)) rule++;
          if (lb_rd_ready != 4'b0000 && lb_rd_ready !== exp_mask(k)) badm++;
          if (out_valid) begin
            nvalid++;
            if (out_window !== exp_win(k)) badw++;
          end
          if (line_done) begin
            checks++; if (nvalid !== W - 2) begin errors++; $display("FAIL rot_valid_count_line%0d: got %0d want %0d", k, nvalid, W - 2); end
            checks++; if (badw !== 0) begin errors++; $display("FAIL rot_window_line%0d: got %0d bad windows want 0", k, badw); end
            checks++; if (badm !== 0) begin errors++; $display("FAIL rot_rd_mask_line%0d: got %0d bad masks want 0", k, badm); end
            nvalid = 0; badw = 0; badm = 0;
            k++;
            rot_k = k;
          end
        end
      end
    join
    checks++; if (k !== 8) begin errors++; $display("FAIL rot_lines_done: got %0d want 8", k); end
    checks++; if (pushed !== 10 * W) begin errors++; $display("FAIL rot_pixels_accepted: got %0d want %0d", pushed, 10 * W); end
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL rot_wr_valid: got %0d bad cycles want 0", wr_bad); end
    checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL rot_wr_coverage: got %b want 1111", seen); end
    checks++; if (rule !== 0) begin errors++; $display("FAIL rot_ready_rule: got %0d violations want 0", rule); end
  endtask

  task automatic test_backpressure();
    int fill_m, bad_rdy, bad_wr, nacc, nrd;
    logic acc, rd;
    do_reset();
    push_pixels(3 * W, 0);
    fill_m = 3 * W; bad_rdy = 0; bad_wr = 0; nacc = 0; nrd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid = (i % 3 != 0);
      in_data  = 8'(i);
      #1;
      acc = in_valid && in_ready;
      rd  = (lb_rd_ready != 4'b0000);
      if (in_ready !== (fill_m < 4 * W)) bad_rdy++;
      if (acc && lb_wr_valid == 4'b0000) bad_wr++;
      if (!acc && lb_wr_valid != 4'b0000) bad_wr++;
      @(posedge clk);
      if (acc) nacc++;
      if (rd) nrd++;
      fill_m = fill_m + (acc ? 1 : 0) - (rd ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL bp_in_ready: got %0d bad cycles want 0", bad_rdy); end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL bp_wr_gating: got %0d bad cycles want 0", bad_wr); end
    checks++; if (nrd < W) begin errors++; $display("FAIL bp_reads: got %0d want at least %0d", nrd, W); end
    checks++; if (dut.fill_cnt !== 10'(fill_m)) begin errors++; $display("FAIL bp_fill_cnt: got %0d want %0d", dut.fill_cnt, fill_m); end
  endtask

  task automatic test_reset_mid_read();
    int cyc, nvalid, badw;
    bit found, done;
    do_reset();
    push_pixels(3 * W, 0);
    cyc = 0; found = 0;
    while (!found && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
      if (lb_rd_ready != 4'b0000 && dut.rd_col == 7'd60) found = 1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_col60: got %0b want 1", found); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    checks++; if (lb_rd_ready !== 4'b0000) begin errors++; $display("FAIL mid_state_idle: got %b want 0000", lb_rd_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
    checks++; if (dut.fill_cnt !== 10'd0) begin errors++; $display("FAIL mid_fill_cnt: got %0d want 0", dut.fill_cnt); end
    checks++; if (dut.rd_col !== 7'd0) begin errors++; $display("FAIL mid_rd_col: got %0d want 0", dut.rd_col); end
    rot_k = 20;
    push_pixels(3 * W, 20);
    cyc = 0; nvalid = 0; badw = 0; done = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        nvalid++;
        if (out_window !== exp_win(20)) badw++;
      end
      if (line_done) done = 1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_line_done: got %0b want 1", done); end
    checks++; if (nvalid !== W - 2) begin errors++; $display("FAIL mid_valid_count: got %0d want %0d", nvalid, W - 2); end
    checks++; if (badw !== 0) begin errors++; $display("FAIL mid_window: got %0d bad windows want 0", badw); end
    checks++; if (dut.rd_sel !== 2'd1) begin errors++; $display("FAIL mid_rd_sel: got %0d want 1", dut.rd_sel); end
  endtask

  initial begin
    test_reset();
    test_fill_threshold();
    test_line_output();
    test_rotation();
    test_backpressure();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
